// File: rtl/clock_controller.sv
// clock_controller: run/step/halt clock-enable generator for a slow processor.
// Optional single-step path is compiled in only when SINGLE_STEP_EN is defined.
// Ports:
//   clkin    - system clock, everything on rising edge
//   rst      - asynchronous active-high reset
//   run_req  - run switch level (synchronous)
//   step_btn - raw bouncy pushbutton (asynchronous)
//   halt     - processor halt request (synchronous level)
//   cpu_en   - registered one-cycle processor clock-enable
//   tick_led - toggles after every cpu_en pulse
//   state    - FSM state: 00 IDLE, 01 RUN, 10 STEP, 11 HALTED
module clock_controller #(
    parameter int unsigned PRESCALER = 25_000_000,
    parameter int unsigned DEBOUNCE  = 250_000
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       run_req,
    input  logic       step_btn,
    input  logic       halt,
    output logic       cpu_en,
    output logic       tick_led,
    output logic [1:0] state
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, HALTED = 2'b11} state_t;
    localparam logic [24:0] PMAX = 25'(PRESCALER);
    state_t cur, nxt;
    logic [24:0] cnt;
    logic step_evt;
    logic stay_run;
`ifdef SINGLE_STEP_EN
    localparam logic [19:0] DMAX = 20'(DEBOUNCE - 1);
    logic sync1, sync2, deb, deb_d;
    logic [19:0] dcnt;
    // dcnt counts consecutive cycles the synchronized button disagrees with deb
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            deb_d <= 1'b0;
            dcnt  <= '0;
        end else begin
            sync1 <= step_btn;
            sync2 <= sync1;
            deb_d <= deb;
            if (sync2 == deb) begin
                dcnt <= '0;
            end else if (dcnt == DMAX) begin
                deb  <= sync2;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 20'd1;
            end
        end
    end
    assign step_evt = deb & ~deb_d;
`else
    logic unused_step;
    assign unused_step = step_btn;
    assign step_evt    = 1'b0;
`endif
    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:   nxt = halt ? IDLE : run_req ? RUN : step_evt ? STEP : IDLE;
            RUN:    nxt = halt ? HALTED : run_req ? RUN : IDLE;
            STEP:   nxt = IDLE;
            HALTED: nxt = run_req ? HALTED : IDLE;
        endcase
    end
    // the counter only runs while RUN persists, so it restarts at 0 on each entry
    assign stay_run = (cur == RUN) && (nxt == RUN);
    // cpu_en is registered: a wrap seen this cycle becomes a pulse next cycle,
    // and entering STEP raises it for exactly the cycle spent in STEP
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            cur      <= IDLE;
            cnt      <= '0;
            cpu_en   <= 1'b0;
            tick_led <= 1'b0;
        end else begin
            cur      <= nxt;
            cnt      <= (stay_run && cnt != PMAX) ? cnt + 25'd1 : '0;
            cpu_en   <= (stay_run && cnt == PMAX) || (nxt == STEP);
            tick_led <= tick_led ^ cpu_en;
        end
    end
    assign state = cur;
endmodule

// File: tb/tb_clock_controller.sv
// tb_clock_controller: two DUTs (PRESCALER 3 and 0, DEBOUNCE 4) against a behavioural model.
module tb_clock_controller;
    logic clkin = 1'b0;
    logic rst = 1'b1;
    logic run_req = 1'b0;
    logic step_btn = 1'b0;
    logic halt = 1'b0;
    logic [1:0] en, led;
    logic [1:0] st [2];
    int checks = 0;
    int errors = 0;

    always #5 clkin = ~clkin;

    clock_controller #(.PRESCALER(3), .DEBOUNCE(4)) dut3 (
        .clkin(clkin), .rst(rst), .run_req(run_req), .step_btn(step_btn), .halt(halt),
        .cpu_en(en[0]), .tick_led(led[0]), .state(st[0]));
    clock_controller #(.PRESCALER(0), .DEBOUNCE(4)) dut0 (
        .clkin(clkin), .rst(rst), .run_req(run_req), .step_btn(step_btn), .halt(halt),
        .cpu_en(en[1]), .tick_led(led[1]), .state(st[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // enable period of each instance: PRESCALER+1
    function automatic int per(input int i);
        return i == 0 ? 4 : 1;
    endfunction

    // model: state code, pending pulse, led, and cycles spent in the current RUN stay
    int m_st [2] = '{0, 0};
    bit m_en [2] = '{0, 0};
    bit m_led [2] = '{0, 0};
    int age [2] = '{0, 0};
    bit b1 = 0, b2 = 0, deb = 0, deb_prev = 0;
    bit hist [3] = '{0, 0, 0};

    always @(posedge clkin or posedge rst) begin
        bit ev, all_diff;
        int nx;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_st[i] = 0; m_en[i] = 0; m_led[i] = 0; age[i] = 0;
            end
            b1 = 0; b2 = 0; deb = 0; deb_prev = 0;
            for (int j = 0; j < 3; j++) hist[j] = 0;
        end else begin
`ifdef SINGLE_STEP_EN
            ev = deb && !deb_prev;
`else
            ev = 0;
`endif
            // accepted once the last 4 synchronized samples all disagree with deb
            all_diff = (b2 != deb);
            for (int j = 0; j < 3; j++) all_diff = all_diff && (hist[j] != deb);
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = b2;
            deb_prev = deb;
            if (all_diff) deb = b2;
            b2 = b1;
            b1 = step_btn;
            for (int i = 0; i < 2; i++) begin
                case (m_st[i])
                    0: nx = halt ? 0 : run_req ? 1 : ev ? 2 : 0;
                    1: nx = halt ? 3 : run_req ? 1 : 0;
                    2: nx = 0;
                    default: nx = run_req ? 3 : 0;
                endcase
                m_led[i] = m_led[i] ^ m_en[i];
                m_en[i] = (nx == 2) || (m_st[i] == 1 && nx == 1 && age[i] % per(i) == per(i) - 1);
                age[i] = (m_st[i] == 1 && nx == 1) ? age[i] + 1 : 0;
                m_st[i] = nx;
            end
        end
    end

    always @(posedge clkin) begin
        #2;
        chk("en_p3", en[0], m_en[0]);
        chk("led_p3", led[0], m_led[0]);
        chk("state_p3", st[0], m_st[0]);
        chk("en_p0", en[1], m_en[1]);
        chk("led_p0", led[1], m_led[1]);
        chk("state_p0", st[1], m_st[1]);
    end

    task automatic cyc;
        @(posedge clkin);
        #3;
    endtask

    initial begin
        int n3, n0, first, led5, nstep, hold;
        repeat (3) cyc;
        chk("rst_state", st[0], 0);
        chk("rst_en", en[0], 0);
        chk("rst_led", led[0], 0);
        rst = 0;
        cyc;
        // run: pulses every 4th cycle, first 4 cycles after RUN is seen
        run_req = 1;
        cyc;
        chk("run_entry", st[0], 1);
        n3 = 0; n0 = 0; first = 0; led5 = 0;
        for (int k = 1; k <= 41; k++) begin
            cyc;
            if (en[0]) begin
                n3++;
                if (first == 0) first = k;
            end
            if (en[1]) n0++;
            if (k == 5) led5 = led[0];
        end
        chk("run_first", first, 4);
        chk("run_pulses", n3, 10);
        chk("run_led5", led5, 1);
        chk("zp_pulses", n0, 41);
        // halt on the cycle the counter reaches 3
        cyc;
        cyc;
        halt = 1;
        cyc;
        chk("halt_en", en[0], 0);
        chk("halt_state", st[0], 3);
        halt = 0;
        run_req = 0;
        cyc;
        chk("halt_to_idle", st[0], 0);
        run_req = 1;
        cyc;
        chk("rerun", st[0], 1);
        // button pressed in RUN is discarded
        step_btn = 1;
        n3 = 0;
        repeat (12) begin
            cyc;
            n3 += int'(en[0]);
        end
        chk("run_step_pulses", n3, 3);
        chk("run_step_state", st[0], 1);
        run_req = 0;
        cyc;
        step_btn = 0;
        repeat (10) cyc;
        // button pressed in HALTED is discarded
        run_req = 1;
        cyc;
        halt = 1;
        cyc;
        step_btn = 1;
        n3 = 0;
        repeat (10) begin
            cyc;
            n3 += int'(en[0]);
        end
        chk("halted_step_pulses", n3, 0);
        chk("halted_step_state", st[0], 3);
        halt = 0;
        run_req = 0;
        cyc;
        step_btn = 0;
        repeat (10) cyc;
        // bouncy press in IDLE
        n3 = 0; nstep = 0;
        step_btn = 1; cyc;
        step_btn = 0; cyc;
        step_btn = 1; cyc;
        step_btn = 0; cyc;
        step_btn = 1;
        repeat (16) begin
            cyc;
            n3 += int'(en[0]);
            nstep += int'(st[0] == 2'b10);
        end
`ifdef SINGLE_STEP_EN
        chk("step_pulses", n3, 1);
        chk("step_visits", nstep, 1);
`else
        chk("step_pulses", n3, 0);
        chk("step_visits", nstep, 0);
`endif
        n3 = 0;
        repeat (10) begin
            cyc;
            n3 += int'(en[0]);
        end
        chk("step_hold_pulses", n3, 0);
        chk("step_hold_state", st[0], 0);
        step_btn = 0;
        repeat (10) cyc;
        // reset while the counter sits at 2
        run_req = 1;
        cyc;
        cyc;
        cyc;
        rst = 1;
        #1;
        chk("mid_rst_en", en[0], 0);
        chk("mid_rst_led", led[0], 0);
        chk("mid_rst_state", st[0], 0);
        chk("mid_rst_en_p0", en[1], 0);
        chk("mid_rst_led_p0", led[1], 0);
        run_req = 0;
        cyc;
        rst = 0;
        n3 = 0;
        repeat (10) begin
            cyc;
            n3 += int'(en[0]) + int'(en[1]);
        end
        chk("post_rst_pulses", n3, 0);
        // zero prescaler: enable every RUN cycle, gone once run_req=0 is sampled
        run_req = 1;
        cyc;
        n0 = 0;
        repeat (5) begin
            cyc;
            n0 += int'(en[1]);
        end
        chk("zp_every", n0, 5);
        run_req = 0;
        cyc;
        chk("zp_drop", en[1], 0);
        chk("zp_idle", st[1], 0);
        // random traffic against the model
        hold = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) run_req = ~run_req;
            halt = ($urandom_range(0, 15) == 0);
            if (hold == 0) begin
                step_btn = ~step_btn;
                hold = $urandom_range(1, 8);
            end else begin
                hold--;
            end
            rst = ($urandom_range(0, 399) == 0);
            cyc;
        end
        rst = 0;
        cyc;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
